// File: rtl/signed_acc_ovf_pkg.sv
// Shared constants for the signed accumulator: FSM encodings and saturation limits.
package signed_acc_ovf_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Limits are returned 32 bits wide; callers truncate to their own WIDTH.
  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_min(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/signed_acc_ovf_add.sv
// Ripple-carry adder with cin=0 and signed-overflow detect (carry into MSB xor carry out).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add_ovf_w #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);
  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .s   (sum[i]),
      .cout(carry[i+1])
    );
  end

  assign ovf = carry[WIDTH] ^ carry[WIDTH-1];
endmodule

// File: rtl/signed_acc_ovf.sv
// Burst signed accumulator with saturate/wrap on overflow, sticky flag and event count.
// state    | meaning
// ST_IDLE  | waiting for start; last result still readable
// ST_ACCUM | accepting samples, one per cycle
// ST_DONE  | result presented until out_ready
module signed_acc_ovf
  import signed_acc_ovf_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 4,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_ovf_cnt
);

  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [LEN_W-1:0] remaining;
  logic             ovf_flag;
  logic [CNT_W-1:0] ovf_cnt;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;
  logic [WIDTH-1:0] next_acc;

  add_ovf_w #(.WIDTH(WIDTH)) u_add (
    .a  (acc),
    .b  (in_data),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // On overflow both operands share a sign, so acc's MSB picks the rail.
  always_comb begin
    next_acc = add_sum;
    if (add_ovf && SAT_EN)
      next_acc = acc[WIDTH-1] ? SAT_MIN : SAT_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf_flag  <= 1'b0;
      ovf_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= len;
            acc       <= '0;
            ovf_flag  <= 1'b0;
            ovf_cnt   <= '0;
            state     <= (len == '0) ? ST_DONE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            acc       <= next_acc;
            remaining <= remaining - LEN_W'(1);
            if (add_ovf) begin
              ovf_flag <= 1'b1;
              if (ovf_cnt != '1)
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
            if (remaining == LEN_W'(1))
              state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (state == ST_ACCUM);
  assign out_valid   = (state == ST_DONE);
  assign out_sum     = acc;
  assign out_ovf     = ovf_flag;
  assign out_ovf_cnt = ovf_cnt;

endmodule

// File: tb/tb_signed_acc_ovf.sv
// Directed bench: one saturating and one wrapping instance share all inputs.
module tb_signed_acc_ovf;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready;
  logic [3:0] len, in_data;
  logic       s_in_ready, s_out_valid, s_out_ovf;
  logic [3:0] s_out_sum, s_out_ovf_cnt;
  logic       w_in_ready, w_out_valid, w_out_ovf;
  logic [3:0] w_out_sum, w_out_ovf_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signed_acc_ovf #(.WIDTH(4), .LEN_W(4), .CNT_W(4), .SAT_EN(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_sum(s_out_sum), .out_ovf(s_out_ovf), .out_ovf_cnt(s_out_ovf_cnt)
  );

  signed_acc_ovf #(.WIDTH(4), .LEN_W(4), .CNT_W(4), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(w_in_ready),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_sum(w_out_sum), .out_ovf(w_out_ovf), .out_ovf_cnt(w_out_ovf_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] d);
    checks++;
    if (s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b expected 1", s_in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (s_out_valid !== 1'b0 || w_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: out_valid=%b/%b expected 0", s_out_valid, w_out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({s_in_ready, s_out_valid, s_out_sum, s_out_ovf, s_out_ovf_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b vld=%b sum=%h ovf=%b cnt=%h expected all 0",
               s_in_ready, s_out_valid, s_out_sum, s_out_ovf, s_out_ovf_cnt);
    end
  endtask

  task automatic test_no_overflow();
    do_start(4'd3);
    checks++;
    if (s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL t1_start_latency: in_ready=%b expected 1", s_in_ready);
    end
    send(4'd2);
    send(4'd3);
    checks++;
    if (s_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_early_valid: out_valid=%b expected 0", s_out_valid);
    end
    send(4'd1);
    checks++;
    if (s_out_valid !== 1'b1 || s_out_sum !== 4'd6 || s_out_ovf !== 1'b0 || s_out_ovf_cnt !== 4'd0) begin
      errors++;
      $display("FAIL t1_result: vld=%b sum=%h ovf=%b cnt=%h expected 1 6 0 0",
               s_out_valid, s_out_sum, s_out_ovf, s_out_ovf_cnt);
    end
    checks++;
    if (w_out_sum !== 4'd6 || w_out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL t1_wrap_result: sum=%h ovf=%b expected 6 0", w_out_sum, w_out_ovf);
    end
    release_result();
  endtask

  task automatic test_pos_overflow();
    do_start(4'd2);
    send(4'd5);
    send(4'd4);
    checks++;
    if (s_out_sum !== 4'b0111 || s_out_ovf !== 1'b1 || s_out_ovf_cnt !== 4'd1) begin
      errors++;
      $display("FAIL t2_pos_sat: sum=%h ovf=%b cnt=%h expected 7 1 1",
               s_out_sum, s_out_ovf, s_out_ovf_cnt);
    end
    checks++;
    if (w_out_sum !== 4'b1001 || w_out_ovf !== 1'b1 || w_out_ovf_cnt !== 4'd1) begin
      errors++;
      $display("FAIL t3_pos_wrap: sum=%h ovf=%b cnt=%h expected 9 1 1",
               w_out_sum, w_out_ovf, w_out_ovf_cnt);
    end
    release_result();
  endtask

  task automatic test_neg_overflow();
    do_start(4'd2);
    send(4'hA);
    send(4'hB);
    checks++;
    if (s_out_sum !== 4'b1000 || s_out_ovf !== 1'b1 || s_out_ovf_cnt !== 4'd1) begin
      errors++;
      $display("FAIL t3_neg_sat: sum=%h ovf=%b cnt=%h expected 8 1 1",
               s_out_sum, s_out_ovf, s_out_ovf_cnt);
    end
    checks++;
    if (w_out_sum !== 4'b0101 || w_out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL t3_neg_wrap: sum=%h ovf=%b expected 5 1", w_out_sum, w_out_ovf);
    end
    release_result();
  endtask

  task automatic test_handshake();
    do_start(4'd3);
    send(4'd1);
    in_data = 4'd5;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_out_sum !== 4'd1) begin
        errors++;
        $display("FAIL t4_gap: rdy=%b vld=%b sum=%h expected 1 0 1", s_in_ready, s_out_valid, s_out_sum);
      end
    end
    send(4'd2);
    tick();
    send(4'd3);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      len   = 4'd5;
      tick();
      checks++;
      if (s_out_valid !== 1'b1 || s_out_sum !== 4'd6 || s_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL t4_hold: vld=%b sum=%h rdy=%b expected 1 6 0", s_out_valid, s_out_sum, s_in_ready);
      end
    end
    start = 1'b0;
    release_result();
    checks++;
    if (s_in_ready !== 1'b0 || s_out_sum !== 4'd6) begin
      errors++;
      $display("FAIL t4_idle: rdy=%b sum=%h expected 0 6", s_in_ready, s_out_sum);
    end
  endtask

  task automatic test_edges();
    do_start(4'd0);
    checks++;
    if (s_out_valid !== 1'b1 || s_out_sum !== 4'd0 || s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL t5_len0: vld=%b sum=%h rdy=%b expected 1 0 0", s_out_valid, s_out_sum, s_in_ready);
    end
    release_result();
    do_start(4'd15);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (s_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL t5_len15_early: out_valid=%b expected 0 at sample %0d", s_out_valid, i);
      end
      send(4'd7);
    end
    checks++;
    if (s_out_valid !== 1'b1 || s_out_sum !== 4'd7 || s_out_ovf !== 1'b1 || s_out_ovf_cnt !== 4'd14) begin
      errors++;
      $display("FAIL t5_len15: vld=%b sum=%h ovf=%b cnt=%0d expected 1 7 1 14",
               s_out_valid, s_out_sum, s_out_ovf, s_out_ovf_cnt);
    end
    release_result();
  endtask

  task automatic test_reset_mid_burst();
    do_start(4'd3);
    send(4'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({s_in_ready, s_out_valid, s_out_sum, s_out_ovf, s_out_ovf_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL t6_reset: rdy=%b vld=%b sum=%h ovf=%b cnt=%h expected all 0",
               s_in_ready, s_out_valid, s_out_sum, s_out_ovf, s_out_ovf_cnt);
    end
    do_start(4'd2);
    send(4'd1);
    send(4'd2);
    checks++;
    if (s_out_valid !== 1'b1 || s_out_sum !== 4'd3 || s_out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL t6_fresh: vld=%b sum=%h ovf=%b expected 1 3 0", s_out_valid, s_out_sum, s_out_ovf);
    end
    release_result();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = 4'd0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;
    test_reset();
    test_no_overflow();
    test_pos_overflow();
    test_neg_overflow();
    test_handshake();
    test_edges();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
